// File: rtl/core_pkg.sv
// Shared core definitions: PRF geometry defaults, operand types and the
// read-port output-stage state encoding {out_valid, skid_valid}.
package core_pkg;
  localparam int DEF_NUM_REGS = 64;
  localparam int DEF_TAG_W    = 6;
  localparam int DEF_REG_W    = 32;
  localparam int DEF_ID_W     = 8;

  typedef logic [DEF_TAG_W-1:0] prf_tag_t;
  typedef logic [DEF_REG_W-1:0] prf_data_t;

  typedef logic [1:0] rp_state_t;
  localparam rp_state_t RP_EMPTY = 2'b00;
  localparam rp_state_t RP_ONE   = 2'b10;
  localparam rp_state_t RP_FULL  = 2'b11;
endpackage

// File: rtl/prf_read_mux.sv
// Combinational operand select for one source tag: same-cycle write bypass
// first, then the PRF entry, and zero for tags beyond the register count.
module prf_read_mux import core_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int REG_W    = DEF_REG_W
) (
  input  logic [TAG_W-1:0]          tag,
  input  logic [NUM_REGS*REG_W-1:0] prf_flat,
  input  logic                      wr_en,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [REG_W-1:0]          wr_data,
  output logic [REG_W-1:0]          data
);

  always_comb begin
    data = '0;
    // Loop-compare keeps out-of-range tags at zero without an out-of-bounds slice.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (tag == TAG_W'(i)) data = prf_flat[i*REG_W +: REG_W];
    end
    if (wr_en && (wr_tag == tag)) data = wr_data;
  end

endmodule

// File: rtl/prf_read_port.sv
// PRF read port: accepts two-tag read requests, returns both operands one
// cycle later through an output register backed by a one-entry skid buffer.
module prf_read_port import core_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      rst_aH,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [TAG_W-1:0]          req_tag_a,
  input  logic [TAG_W-1:0]          req_tag_b,
  input  logic [ID_W-1:0]           req_id,
  input  logic [NUM_REGS*REG_W-1:0] prf_flat,
  input  logic                      wr_en,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [REG_W-1:0]          wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REG_W-1:0]          rsp_data_a,
  output logic [REG_W-1:0]          rsp_data_b,
  output logic [ID_W-1:0]           rsp_id
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its payload stable while valid && !ready.

  logic             out_valid, skid_valid;
  logic [REG_W-1:0] out_a, out_b, skid_a, skid_b;
  logic [ID_W-1:0]  out_id, skid_id;
  logic [REG_W-1:0] rd_a, rd_b;
  logic             accept;
  rp_state_t        state;

  assign state     = {out_valid, skid_valid};
  assign req_ready = !skid_valid;
  assign accept    = req_valid && req_ready;

  assign rsp_valid  = out_valid;
  assign rsp_data_a = out_a;
  assign rsp_data_b = out_b;
  assign rsp_id     = out_id;

  prf_read_mux #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .REG_W(REG_W)) u_mux_a (
    .tag(req_tag_a), .prf_flat(prf_flat), .wr_en(wr_en), .wr_tag(wr_tag),
    .wr_data(wr_data), .data(rd_a)
  );

  prf_read_mux #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .REG_W(REG_W)) u_mux_b (
    .tag(req_tag_b), .prf_flat(prf_flat), .wr_en(wr_en), .wr_tag(wr_tag),
    .wr_data(wr_data), .data(rd_b)
  );

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_id     <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_id    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        RP_EMPTY: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_a     <= rd_a;
            out_b     <= rd_b;
            out_id    <= req_id;
          end
        end
        RP_ONE: begin
          if (accept && rsp_ready) begin
            out_a  <= rd_a;
            out_b  <= rd_b;
            out_id <= req_id;
          end else if (accept) begin
            // Consumer stalled: the younger request parks in the skid.
            skid_valid <= 1'b1;
            skid_a     <= rd_a;
            skid_b     <= rd_b;
            skid_id    <= req_id;
          end else if (rsp_ready) begin
            out_valid <= 1'b0;
          end
        end
        RP_FULL: begin
          if (rsp_ready) begin
            skid_valid <= 1'b0;
            out_a      <= skid_a;
            out_b      <= skid_b;
            out_id     <= skid_id;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  state_01_unreachable: assert property (@(posedge clk) disable iff (rst_aH)
    state != 2'b01);

endmodule
